chacha20_stream_xor: RTL

CHACHA20_STREAM_XOR -- requirements
Module: chacha20_stream_xor

---
 rtl/chacha20_pkg.sv | 17 +
 rtl/axis_out_reg.sv | 37 +++
 rtl/chacha20_stream_xor.sv | 117 +++++++++++
 3 files changed

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 stream-cipher constants and the FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chacha20_pkg;

  localparam int CHACHA_BLOCK_BITS  = 512;
  localparam int CHACHA_WORD_BITS   = 32;
  localparam int CHACHA_BLOCK_WORDS = CHACHA_BLOCK_BITS / CHACHA_WORD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT_KS = 2'd2,
    ST_STREAM  = 2'd3
  } xor_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-beat AXI-Stream output register.
// Latency: one cycle from load to m_axis_tvalid.
// Backpressure: holds data/last stable while m_axis_tready=0; load_rdy=0 while full and stalled.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  load_vld,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  load_last,
  output logic                  load_rdy,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  // A new beat may enter when the register is empty or is draining this cycle.
  assign load_rdy = !m_axis_tvalid || m_axis_tready;

  // Capture an accepted beat; otherwise clear valid once the consumer takes it.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load_vld && load_rdy) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_dat;
      m_axis_tlast  <= load_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha20_stream_xor.sv
// XORs a 32-bit plaintext stream with ChaCha20 keystream blocks fetched from an external generator.
// Latency: one cycle per beat once a keystream block is buffered; a block fetch stalls the input.
// Backpressure: s_axis_tready follows the output register; no input accepted outside STREAM.
module chacha20_stream_xor
  import chacha20_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                         i_aclk,
  input  logic                         i_areset,
  input  logic                         i_enable,
  input  logic [31:0]                  i_counter_init,
  output logic                         o_start,
  output logic [31:0]                  o_counter,
  input  logic [CHACHA_BLOCK_BITS-1:0] i_keystream,
  input  logic                         i_keystream_valid,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         o_counter_wrap
);

  localparam int                IDX_W    = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  xor_state_t            state;
  logic [31:0]           blk_ctr;
  logic [32:0]           ctr_next;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] ks_buf [BLOCK_WORDS];
  logic                  out_rdy;
  logic                  beat_acc;

  // Carry out of the increment marks a counter wrap.
  assign ctr_next      = {1'b0, blk_ctr} + 33'd1;
  assign s_axis_tready = (state == ST_STREAM) && out_rdy;
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .i_aclk        (i_aclk),
    .i_areset      (i_areset),
    .load_vld      (beat_acc),
    .load_dat      (s_axis_tdata ^ ks_buf[idx]),
    .load_last     (s_axis_tlast),
    .load_rdy      (out_rdy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // Packet FSM: fetch a block, stream through its words, refetch at block end, stop on tlast.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      state          <= ST_IDLE;
      o_start        <= 1'b0;
      o_counter      <= '0;
      blk_ctr        <= '0;
      o_counter_wrap <= 1'b0;
      idx            <= '0;
      for (int k = 0; k < BLOCK_WORDS; k++) ks_buf[k] <= '0;
    end else begin
      // o_start is raised on entry to REQUEST so it is high for exactly that cycle.
      o_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          blk_ctr <= i_counter_init;
          idx     <= '0;
          if (i_enable) begin
            o_start   <= 1'b1;
            o_counter <= i_counter_init;
            state     <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          state <= ST_WAIT_KS;
        end
        ST_WAIT_KS: begin
          if (i_keystream_valid) begin
            for (int k = 0; k < BLOCK_WORDS; k++)
              ks_buf[k] <= i_keystream[k*DATA_WIDTH +: DATA_WIDTH];
            idx   <= '0;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_acc) begin
            if (s_axis_tlast) begin
              // End of packet wins over end of block: unused words are dropped.
              idx   <= '0;
              state <= ST_IDLE;
            end else if (idx == LAST_IDX) begin
              blk_ctr   <= ctr_next[31:0];
              o_counter <= ctr_next[31:0];
              o_start   <= 1'b1;
              idx       <= '0;
              state     <= ST_REQUEST;
              if (ctr_next[32]) o_counter_wrap <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
